// File: rtl/weight_frame_loader.sv
// Frame parser that loads a length-prefixed, checksummed payload into the weight RAM.
// Optional inter-byte timeout enabled by defining WEIGHT_FRAME_LOADER_TIMEOUT_EN.
module weight_frame_loader #(
    parameter int         TOTAL_BYTES    = 715,
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    output logic       byte_ready,
    output logic       wr_en,
    output logic [9:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       busy,
    output logic       done,
    output logic       err
);

    // byte_valid/byte_ready: a byte transfers on a rising clk edge where both are high;
    // byte_ready does not depend on byte_valid.

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_PAYLOAD,
        S_CSUM,
        S_CHECK
    } state_t;

    localparam logic [15:0] MAX_LEN = 16'(TOTAL_BYTES);

    if (TOTAL_BYTES < 1 || TOTAL_BYTES > 1024) begin : g_bad_total
        $error("TOTAL_BYTES must be in 1..1024 to fit the 10-bit address");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be positive");
    end

    state_t      state;
    state_t      state_nxt;
    logic        out_en;
    logic        accept;
    logic        is_sync;
    logic [7:0]  len_hi;
    logic [15:0] len;
    logic [15:0] len_in;
    logic        len_bad;
    logic [15:0] idx;
    logic        last_payload;
    logic [7:0]  sum;
    logic [7:0]  csum;
    logic        timeout;

    // out_en holds byte_ready low through reset and releases it on the first edge after.
    assign byte_ready   = out_en && (state != S_CHECK);
    assign busy         = (state != S_IDLE);
    assign accept       = byte_valid && byte_ready;
    assign is_sync      = (byte_data == SYNC_BYTE);
    assign len_in       = {len_hi, byte_data};
    assign len_bad      = (len_in == 16'd0) || (len_in > MAX_LEN);
    assign last_payload = (idx == len - 16'd1);

`ifdef WEIGHT_FRAME_LOADER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] to_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt <= '0;
        end else if (state == S_IDLE || accept) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + TW'(1);
        end
    end

    // Fires on the TIMEOUT_CYCLES-th consecutive cycle without an accepted byte.
    assign timeout = (state != S_IDLE) && (state != S_CHECK) && !accept &&
                     (to_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (accept && is_sync) state_nxt = S_LEN_HI;
            S_LEN_HI:  if (accept) state_nxt = S_LEN_LO;
            S_LEN_LO:  if (accept) state_nxt = len_bad ? S_IDLE : S_PAYLOAD;
            S_PAYLOAD: if (accept && last_payload) state_nxt = S_CSUM;
            S_CSUM:    if (accept) state_nxt = S_CHECK;
            S_CHECK:   state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
        if (timeout) begin
            state_nxt = S_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_en  <= 1'b0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            done    <= 1'b0;
            err     <= 1'b0;
            len_hi  <= '0;
            len     <= '0;
            idx     <= '0;
            sum     <= '0;
            csum    <= '0;
        end else begin
            out_en <= 1'b1;
            wr_en  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept && is_sync) begin
                        done <= 1'b0;
                        err  <= 1'b0;
                        sum  <= '0;
                        idx  <= '0;
                    end
                end
                S_LEN_HI: begin
                    if (accept) len_hi <= byte_data;
                end
                S_LEN_LO: begin
                    if (accept) begin
                        len <= len_in;
                        if (len_bad) err <= 1'b1;
                    end
                end
                S_PAYLOAD: begin
                    // Write is registered, so it lands on the cycle after the accept.
                    if (accept) begin
                        wr_en   <= 1'b1;
                        wr_addr <= idx[9:0];
                        wr_data <= byte_data;
                        sum     <= sum + byte_data;
                        idx     <= idx + 16'd1;
                    end
                end
                S_CSUM: begin
                    if (accept) csum <= byte_data;
                end
                S_CHECK: begin
                    if (csum == sum) begin
                        done <= 1'b1;
                    end else begin
                        err <= 1'b1;
                    end
                end
                default: ;
            endcase
            if (timeout) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_weight_frame_loader.sv
// Randomized bench for weight_frame_loader: a stream-level frame parser model predicts
// RAM writes and the done/err/busy status; writes are scoreboarded through exp_q.
module tb_weight_frame_loader;

    localparam int         TOTAL_BYTES    = 715;
    localparam logic [7:0] SYNC           = 8'hA5;
    localparam int         TIMEOUT_CYCLES = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       byte_valid = 1'b0;
    logic [7:0] byte_data = 8'h00;
    logic       byte_ready;
    logic       wr_en;
    logic [9:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;
    logic       done;
    logic       err;

    weight_frame_loader #(
        .TOTAL_BYTES(TOTAL_BYTES),
        .SYNC_BYTE(SYNC),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk(clk),
        .rst(rst),
        .byte_valid(byte_valid),
        .byte_data(byte_data),
        .byte_ready(byte_ready),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .busy(busy),
        .done(done),
        .err(err)
    );

    // clock / reset-independent watchdog
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    int          n_checks = 0;
    int          n_errors = 0;
    int          gap_max = 0;
    logic [17:0] exp_q[$];
    logic [17:0] exp_last = '0;
    logic [7:0]  stream[$];
    logic        m_done = 1'b0;
    logic        m_err = 1'b0;
    logic        m_busy = 1'b0;
    logic        m_csum_last = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Write scoreboard: every strobe must match the next predicted (addr,data);
    // between strobes the write bus must hold the last write.
    always @(negedge clk) begin
        logic [17:0] e;
        if (rst) begin
            exp_last = '0;
        end else if (wr_en) begin
            check("wr_addr_range", 32'(wr_addr < 10'(TOTAL_BYTES)), 32'(1));
            if (exp_q.size() == 0) begin
                check("wr_unexpected", 32'(exp_q.size()), 32'(1));
            end else begin
                e = exp_q.pop_front();
                check("wr_addr_data", 32'({wr_addr, wr_data}), 32'(e));
                exp_last = e;
            end
        end else begin
            check("wr_hold", 32'({wr_addr, wr_data}), 32'(exp_last));
        end
    end

    // Reference model: walks the byte stream frame by frame with plain arithmetic.
    task automatic model_run();
        int pos = 0;
        int n = stream.size();
        int len;
        int sum;
        while (pos < n) begin
            m_csum_last = 1'b0;
            if (stream[pos] != SYNC) begin
                pos++;
                continue;
            end
            m_done = 1'b0;
            m_err  = 1'b0;
            m_busy = 1'b1;
            pos++;
            if (pos + 1 >= n) begin
                pos = n;
                continue;
            end
            len = int'(stream[pos]) * 256 + int'(stream[pos + 1]);
            pos += 2;
            if (len == 0 || len > TOTAL_BYTES) begin
                m_err  = 1'b1;
                m_busy = 1'b0;
                continue;
            end
            sum = 0;
            for (int i = 0; i < len && pos < n; i++) begin
                exp_q.push_back({10'(i), stream[pos]});
                sum += int'(stream[pos]);
                pos++;
            end
            if (pos >= n) continue;
            m_busy = 1'b0;
            if ((sum % 256) == int'(stream[pos])) m_done = 1'b1;
            else m_err = 1'b1;
            pos++;
            m_csum_last = (pos == n);
        end
    endtask

    task automatic push(input logic [7:0] b);
        stream.push_back(b);
    endtask

    // Driver: called at a negedge, returns at the negedge after the byte is accepted.
    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        if (gap_max > 0) repeat ($urandom_range(0, gap_max)) @(negedge clk);
        byte_valid = 1'b1;
        byte_data  = b;
        while (!byte_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!byte_ready) begin
            check("ready_wait", 32'(byte_ready), 32'(1));
            byte_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic run_stream();
        model_run();
        foreach (stream[i]) send_byte(stream[i]);
        if (m_csum_last) begin
            check("check_ready", 32'(byte_ready), 32'(0));
            check("check_busy", 32'(busy), 32'(1));
            check("check_done_early", 32'(done), 32'(0));
        end
        @(negedge clk);
        check("done", 32'(done), 32'(m_done));
        check("err", 32'(err), 32'(m_err));
        check("busy", 32'(busy), 32'(m_busy));
        check("ready", 32'(byte_ready), 32'(1));
        check("wr_pending", 32'(exp_q.size()), 32'(0));
        stream.delete();
    endtask

    task automatic do_reset();
        byte_valid = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(byte_ready), 32'(0));
        check("rst_wr_en", 32'(wr_en), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_err", 32'(err), 32'(0));
        check("rst_wr_bus", 32'({wr_addr, wr_data}), 32'(0));
        rst = 1'b0;
        m_done = 1'b0;
        m_err  = 1'b0;
        m_busy = 1'b0;
        exp_q.delete();
        #1;
        check("ready_before_edge", 32'(byte_ready), 32'(0));
        @(posedge clk);
        #1;
        check("ready_after_edge", 32'(byte_ready), 32'(1));
        @(negedge clk);
    endtask

    initial begin
        logic [15:0] len;
        logic [7:0]  b;
        int          sum;
        int          ng;
        int          r;

        do_reset();

        // good frame
        push(8'hA5); push(8'h00); push(8'h03); push(8'h11); push(8'h22); push(8'h33); push(8'h66);
        run_stream();
        // bad checksum
        push(8'hA5); push(8'h00); push(8'h02); push(8'h01); push(8'h02); push(8'h04);
        run_stream();
        // LEN=716, then a fresh sync clears err
        push(8'hA5); push(8'h02); push(8'hCC);
        run_stream();
        push(8'hA5);
        run_stream();
        do_reset();
        // garbage before sync; sync values inside the frame are data
        push(8'h00); push(8'hFF); push(8'hA5); push(8'h00); push(8'h01); push(8'hA5); push(8'hA5);
        run_stream();
        // LEN=0
        push(8'hA5); push(8'h00); push(8'h00);
        run_stream();

        // maximum-length frame
        push(SYNC); push(8'h02); push(8'hCB);
        sum = 0;
        for (int i = 0; i < TOTAL_BYTES; i++) begin
            b = 8'($urandom_range(0, 255));
            push(b);
            sum += int'(b);
        end
        push(8'(sum % 256));
        run_stream();

        // reset after payload byte 5 of a 715-byte frame, then a fresh frame
        push(SYNC); push(8'h02); push(8'hCB);
        for (int i = 0; i < 5; i++) push(8'($urandom_range(0, 255)));
        run_stream();
        do_reset();
        push(8'hA5); push(8'h00); push(8'h02); push(8'h10); push(8'h20); push(8'h30);
        run_stream();

        // stall inside PAYLOAD
        push(8'hA5); push(8'h00); push(8'h04); push(8'h01); push(8'h02);
        run_stream();
        repeat (18) @(negedge clk);
`ifdef WEIGHT_FRAME_LOADER_TIMEOUT_EN
        check("stall_err", 32'(err), 32'(1));
        check("stall_busy", 32'(busy), 32'(0));
`else
        check("stall_err", 32'(err), 32'(0));
        check("stall_busy", 32'(busy), 32'(1));
`endif
        do_reset();

        // randomized frames with valid gaps
        gap_max = 3;
        for (int it = 0; it < 40; it++) begin
            ng = $urandom_range(0, 2);
            for (int g = 0; g < ng; g++) begin
                b = 8'($urandom_range(0, 255));
                if (b == SYNC) b = 8'h00;
                push(b);
            end
            r = $urandom_range(0, 9);
            if (r == 0) len = 16'd0;
            else if (r == 1) len = 16'($urandom_range(TOTAL_BYTES + 1, 65535));
            else len = 16'($urandom_range(1, 24));
            push(SYNC); push(len[15:8]); push(len[7:0]);
            if (len != 16'd0 && len <= 16'(TOTAL_BYTES)) begin
                sum = 0;
                for (int i = 0; i < int'(len); i++) begin
                    b = ($urandom_range(0, 3) == 0) ? SYNC : 8'($urandom_range(0, 255));
                    push(b);
                    sum += int'(b);
                end
                if ($urandom_range(0, 2) == 0) sum += $urandom_range(1, 255);
                push(8'(sum % 256));
            end
            run_stream();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
